plot_arbiter: RTL
=================

PLOT_ARBITER -- requirements
Module: plot_arbiter

Interface
REQ-001 Parameter X_SCREEN_PIXELS, default 8'd160, horizontal pixel count; x >= this SHALL be clipped.
REQ-002 Parameter Y_SCREEN_PIXELS, default 7'd120, vertical pixel count; y >= this SHALL be clipped.
REQ-003 Parameter BURST_MAX, default 15'd19200, maximum plot strobes per tenure before forced hand-off.
REQ-004 Clock  input  1  sole clock, all state on posedge.
REQ-005 Reset  input  1  asynchronous, active-low; clears all state immediately, independent of Clock.
REQ-006 req  input  3  per-requester request, bit i = requester i; held high for the whole burst.
REQ-007 iX0, iX1, iX2  input  8 each  requester pixel x.
REQ-008 iY0, iY1, iY2  input  7 each  requester pixel y.
REQ-009 iColour0, iColour1, iColour2  input  3 each  requester pixel colour.
REQ-010 iPlot  input  3  per-requester write strobe, bit i = requester i.
REQ-011 gnt  output  3  registered one-hot grant; all-zero when no owner.
REQ-012 oX  output  8,  oY  output  7,  oColour  output  3  registered pixel to the VGA adapter.
REQ-013 oPlot  output  1  registered write enable to the VGA adapter plot input.
REQ-014 clipped  output  1  one-cycle pulse, owner strobe dropped for out-of-range coordinate.
REQ-015 busy  output  1  high in GRANT and GAP.

Function
REQ-016 FSM SHALL have states IDLE, GRANT, GAP; encoded in 2 bits; unused code returns to IDLE.
REQ-017 IDLE: gnt=0; if req!=0, next edge SHALL load gnt with the round-robin winner and enter GRANT; else stay.
REQ-018 Round-robin: search order starts at (last_owner+1) mod 3, wraps; first set req bit wins.
REQ-019 last_owner SHALL update to the winner on every grant.
REQ-020 GRANT: stay while req[owner]=1 and burst count < BURST_MAX.
REQ-021 GRANT -> GAP when req[owner] falls; gnt cleared on that same edge.
REQ-022 Burst count reaches BURST_MAX with another req bit set -> GAP (forced hand-off).
REQ-023 Burst count reaches BURST_MAX with no other req -> stay in GRANT, count cleared to 0.
REQ-024 GAP: exactly one cycle, gnt=0, oPlot=0, then IDLE.
REQ-025 Burst counter: 15 bits, cleared on each grant; +1 per owner iPlot strobe in GRANT, clipped strobes included.
REQ-026 Output latency 1 cycle: in GRANT, the owner's iX/iY/iColour SHALL be registered to oX/oY/oColour every cycle.
REQ-027 oPlot SHALL be iPlot[owner] & (iX < X_SCREEN_PIXELS) & (iY < Y_SCREEN_PIXELS), registered.
REQ-028 clipped SHALL be iPlot[owner] & out-of-range, registered; oPlot and clipped never both high.
REQ-029 Non-owner iPlot and coordinates SHALL be ignored; no write is queued or replayed.
REQ-030 Outside GRANT, oPlot=0 and clipped=0; oX/oY/oColour hold last value.
REQ-031 req[owner] and iPlot[owner] high in the same cycle the request falls: the strobe is not forwarded (grant ends on req low).

Reset
REQ-032 Reset low SHALL force IDLE, gnt=0, oX=0, oY=0, oColour=3'b000, oPlot=0, clipped=0, busy=0, burst count=0.
REQ-033 Reset SHALL set last_owner=2 so requester 0 wins the first arbitration.
REQ-034 Reset asserted mid-burst SHALL abort the tenure with no further oPlot; no state resumes after release.

Verification
REQ-035 Reset release, req=3'b101 -> next edge gnt=3'b001; req0 dropped -> GAP cycle gnt=0 -> IDLE -> gnt=3'b100.
REQ-036 Owner 1 strobes (x=10,y=20,colour=3'b110) -> following cycle oX=10, oY=20, oColour=3'b110, oPlot=1.
REQ-037 Owner strobes x=160,y=5 then x=3,y=120 -> clipped=1, oPlot=0 on both; burst count=2.
REQ-038 BURST_MAX=4, req=3'b011, owner 0 strobes 4 times -> GAP, then gnt=3'b010; with req=3'b001 alone -> gnt stays 3'b001, count back to 0.
REQ-039 Reset pulsed low mid-burst of owner 2 -> outputs zero asynchronously; after release with req=3'b111 -> gnt=3'b001.

Source files
------------

// File: rtl/plot_arbiter.sv
// -----------------------------------------------------------------------------
// plot_arbiter
//
// Shares a single VGA-adapter pixel-write port among three requesters.
// A requester raises its req bit and holds it for the whole burst. The
// arbiter grants one owner at a time in round-robin order. While the owner
// holds the port, its pixel (x, y, colour) is registered to the adapter
// every cycle, and its plot strobe is forwarded only when the coordinate is
// on screen. Off-screen strobes are dropped and reported on `clipped`.
//
// A tenure ends when the owner drops its request. It is also cut short
// after BURST_MAX strobes if another requester is waiting. Every tenure is
// followed by one dead GAP cycle before the next arbitration.
//
// Ports
//   Clock                  sole clock, all state on posedge
//   Reset                  asynchronous, active-low
//   req[2:0]               per-requester request (held for the burst)
//   iX0..2 / iY0..2        requester pixel coordinate (8 / 7 bits)
//   iColour0..2            requester pixel colour (3 bits)
//   iPlot[2:0]             per-requester write strobe
//   gnt[2:0]               registered one-hot grant, zero when no owner
//   oX / oY / oColour      registered pixel to the VGA adapter
//   oPlot                  registered write enable to the VGA adapter
//   clipped                one-cycle pulse: owner strobe dropped off-screen
//   busy                   high while in GRANT or GAP
// -----------------------------------------------------------------------------
module plot_arbiter #(
  parameter logic [7:0]  X_SCREEN_PIXELS = 8'd160,
  parameter logic [6:0]  Y_SCREEN_PIXELS = 7'd120,
  parameter logic [14:0] BURST_MAX       = 15'd19200
) (
  input  logic       Clock,
  input  logic       Reset,
  input  logic [2:0] req,
  input  logic [7:0] iX0,
  input  logic [7:0] iX1,
  input  logic [7:0] iX2,
  input  logic [6:0] iY0,
  input  logic [6:0] iY1,
  input  logic [6:0] iY2,
  input  logic [2:0] iColour0,
  input  logic [2:0] iColour1,
  input  logic [2:0] iColour2,
  input  logic [2:0] iPlot,
  output logic [2:0] gnt,
  output logic [7:0] oX,
  output logic [6:0] oY,
  output logic [2:0] oColour,
  output logic       oPlot,
  output logic       clipped,
  output logic       busy
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_GRANT = 2'd1,
    S_GAP   = 2'd2
  } state_e;

  state_e      state_q, state_d;
  // Index of the most recent grantee. While in GRANT it is also the current
  // owner, because it is rewritten on every grant.
  logic [1:0]  last_q, last_d;
  logic [14:0] cnt_q, cnt_d;
  logic [2:0]  gnt_q, gnt_d;
  logic [7:0]  ox_q, ox_d;
  logic [6:0]  oy_q, oy_d;
  logic [2:0]  oc_q, oc_d;
  logic        plot_q, plot_d;
  logic        clip_q, clip_d;
  logic        busy_q, busy_d;

  // Owner-selected request inputs
  logic [7:0]  own_x;
  logic [6:0]  own_y;
  logic [2:0]  own_c;
  logic        own_req;
  logic        own_plot;
  logic        own_inr;
  logic        other_req;
  logic [15:0] cnt_inc;
  logic [1:0]  winner;

  // Round-robin pick. The search starts just after the previous owner and
  // wraps around. Only used when at least one request bit is set.
  function automatic logic [1:0] rr_pick(input logic [2:0] r, input logic [1:0] last);
    logic [1:0] s0, s1, s2;
    case (last)
      2'd0:    begin s0 = 2'd1; s1 = 2'd2; s2 = 2'd0; end
      2'd1:    begin s0 = 2'd2; s1 = 2'd0; s2 = 2'd1; end
      default: begin s0 = 2'd0; s1 = 2'd1; s2 = 2'd2; end
    endcase
    if (r[s0])      rr_pick = s0;
    else if (r[s1]) rr_pick = s1;
    else            rr_pick = s2;
  endfunction

  function automatic logic [2:0] onehot(input logic [1:0] idx);
    onehot = 3'b001 << idx;
  endfunction

  // Owner input mux
  always_comb begin
    own_x    = iX2;
    own_y    = iY2;
    own_c    = iColour2;
    own_req  = req[2];
    own_plot = iPlot[2];
    case (last_q)
      2'd0: begin
        own_x = iX0; own_y = iY0; own_c = iColour0;
        own_req = req[0]; own_plot = iPlot[0];
      end
      2'd1: begin
        own_x = iX1; own_y = iY1; own_c = iColour1;
        own_req = req[1]; own_plot = iPlot[1];
      end
      default: ;
    endcase
  end

  assign own_inr   = (own_x < X_SCREEN_PIXELS) && (own_y < Y_SCREEN_PIXELS);
  // gnt_q holds the owner's one-hot bit during GRANT, so masking it leaves
  // only the competing requests.
  assign other_req = |(req & ~gnt_q);
  // One extra bit keeps the compare exact even when BURST_MAX is all ones.
  assign cnt_inc   = {1'b0, cnt_q} + {15'd0, own_plot};
  assign winner    = rr_pick(req, last_q);

  // Next-state / next-output logic
  always_comb begin
    state_d = state_q;
    last_d  = last_q;
    cnt_d   = cnt_q;
    gnt_d   = gnt_q;
    ox_d    = ox_q;
    oy_d    = oy_q;
    oc_d    = oc_q;
    plot_d  = 1'b0;
    clip_d  = 1'b0;

    case (state_q)
      S_IDLE: begin
        gnt_d = 3'b000;
        if (|req) begin
          last_d  = winner;
          gnt_d   = onehot(winner);
          cnt_d   = 15'd0;
          state_d = S_GRANT;
        end
      end

      S_GRANT: begin
        if (!own_req) begin
          // The request falling wins over a strobe in the same cycle.
          state_d = S_GAP;
          gnt_d   = 3'b000;
        end else begin
          ox_d   = own_x;
          oy_d   = own_y;
          oc_d   = own_c;
          plot_d = own_plot & own_inr;
          clip_d = own_plot & ~own_inr;
          cnt_d  = cnt_inc[14:0];
          if (cnt_inc >= {1'b0, BURST_MAX}) begin
            // The burst limit is reached. Hand off if someone is waiting;
            // otherwise keep the port and start a fresh count.
            cnt_d = 15'd0;
            if (other_req) begin
              state_d = S_GAP;
              gnt_d   = 3'b000;
            end
          end
        end
      end

      S_GAP: begin
        gnt_d   = 3'b000;
        state_d = S_IDLE;
      end

      default: begin
        gnt_d   = 3'b000;
        state_d = S_IDLE;
      end
    endcase

    busy_d = (state_d == S_GRANT) || (state_d == S_GAP);
  end

  // Register stage
  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      state_q <= S_IDLE;
      last_q  <= 2'd2;
      cnt_q   <= 15'd0;
      gnt_q   <= 3'b000;
      ox_q    <= 8'd0;
      oy_q    <= 7'd0;
      oc_q    <= 3'b000;
      plot_q  <= 1'b0;
      clip_q  <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      last_q  <= last_d;
      cnt_q   <= cnt_d;
      gnt_q   <= gnt_d;
      ox_q    <= ox_d;
      oy_q    <= oy_d;
      oc_q    <= oc_d;
      plot_q  <= plot_d;
      clip_q  <= clip_d;
      busy_q  <= busy_d;
    end
  end

  assign gnt     = gnt_q;
  assign oX      = ox_q;
  assign oY      = oy_q;
  assign oColour = oc_q;
  assign oPlot   = plot_q;
  assign clipped = clip_q;
  assign busy    = busy_q;

endmodule
